// File: rtl/dfu_led_pkg.sv
// dfu_led_pkg: shared mode codes and timing constants for the status-LED engine
package dfu_led_pkg;
  localparam int PHASE_W = 11;
  typedef enum logic [2:0] {
    LED_OFF        = 3'd0,
    LED_ON         = 3'd1,
    LED_BLINK_SLOW = 3'd2,
    LED_BLINK_FAST = 3'd3,
    LED_BREATHE    = 3'd4,
    LED_HEARTBEAT  = 3'd5,
    LED_ACTIVITY   = 3'd6,
    LED_RSVD       = 3'd7
  } led_mode_e;
  localparam logic [5:0] ACT_STRETCH_MS = 6'd50;
  localparam logic [9:0] HB_OFF0 = 10'd96;
  localparam logic [9:0] HB_ON1  = 10'd192;
  localparam logic [9:0] HB_OFF1 = 10'd288;
endpackage

// File: rtl/dfu_led_channel.sv
// dfu_led_channel: pattern mux, breathe ramp, activity stretch and PWM compare for one LED
module dfu_led_channel
  import dfu_led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [2:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                activity,
  input  logic [PHASE_W-1:0]  phase,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);
  logic [5:0]          stretch;
  logic [PWM_BITS-1:0] duty, duty_d, lvl, breathe;
  logic                heartbeat;
  // breathe ramp folds the phase into a triangle and scales it by brightness
  always_comb begin
    lvl       = phase[10] ? ~phase[9 -: PWM_BITS] : phase[9 -: PWM_BITS];
    breathe   = PWM_BITS'(({{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, brightness}) >> PWM_BITS);
    heartbeat = (phase[9:0] < HB_OFF0) || (phase[9:0] >= HB_ON1 && phase[9:0] < HB_OFF1);
    duty_d    = '0;
    case (led_mode_e'(mode))
      LED_ON:         duty_d = brightness;
      LED_BLINK_SLOW: duty_d = phase[9] ? '0 : brightness;
      LED_BLINK_FAST: duty_d = phase[7] ? '0 : brightness;
      LED_BREATHE:    duty_d = breathe;
      LED_HEARTBEAT:  duty_d = heartbeat ? brightness : '0;
      LED_ACTIVITY:   duty_d = (stretch != '0) ? brightness : '0;
      default:        duty_d = '0;
    endcase
  end
  // a strobe reloads the flash window; otherwise it drains one step per ms tick
  always_ff @(posedge clk)
    stretch <= reset ? '0 : activity ? ACT_STRETCH_MS : (tick && stretch != '0) ? stretch - 6'd1 : stretch;
  // duty is registered, then compared against the free-running PWM counter
  always_ff @(posedge clk) begin
    duty <= reset ? '0 : duty_d;
    led  <= reset ? 1'b0 : (pwm_cnt < duty) | (&duty);
  end
endmodule

// File: rtl/dfu_status_led.sv
// dfu_status_led: multi-channel status-LED engine sharing one ms prescaler, phase and PWM counter
module dfu_status_led
  import dfu_led_pkg::*;
#(
  parameter int CLK_HZ   = 12_000_000,
  parameter int N_CH     = 1,
  parameter int PWM_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3*N_CH-1:0]        mode,
  input  logic [PWM_BITS*N_CH-1:0] brightness,
  input  logic [N_CH-1:0]          activity,
  output logic [N_CH-1:0]          led,
  output logic                     tick_1ms
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int PRE_W = $clog2(DIV + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  logic [PRE_W-1:0]    pre;
  logic [PHASE_W-1:0]  phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  // shared timebase keeps every channel's pattern in lockstep
  always_ff @(posedge clk) begin
    pre      <= (reset || pre == PRE_MAX) ? '0 : pre + 1'b1;
    tick_1ms <= !reset && pre == PRE_MAX;
    phase    <= reset ? '0 : phase + PHASE_W'(tick_1ms);
    pwm_cnt  <= reset ? '0 : pwm_cnt + 1'b1;
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    dfu_led_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick_1ms),
      .mode       (mode[3*i +: 3]),
      .brightness (brightness[PWM_BITS*i +: PWM_BITS]),
      .activity   (activity[i]),
      .phase      (phase),
      .pwm_cnt    (pwm_cnt),
      .led        (led[i])
    );
  end
endmodule

// File: tb/tb_dfu_status_led.sv
// tb_dfu_status_led: randomized scoreboard bench against a cycle-indexed arithmetic model
module tb_dfu_status_led;
  logic       clk = 0;
  logic       reset = 1;
  logic [8:0] mode = '0;
  logic [23:0] brightness = '0;
  logic [2:0] activity = '0;
  logic [2:0] led;
  logic       tick_1ms;

  dfu_status_led #(.CLK_HZ(16000), .N_CH(3), .PWM_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .brightness (brightness),
    .activity   (activity),
    .led        (led),
    .tick_1ms   (tick_1ms)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] led;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int m = 0;
  int dprev[3];
  int last_s[3];

  always @(posedge clk) cyc <= cyc + 1;

  // phase after m edges since reset: one increment per elapsed ms, visible a cycle after the tick
  function automatic int phase_f(input int mm);
    return (mm == 0) ? 0 : ((mm - 1) / 16) % 2048;
  endfunction

  // flash counter: 50 minus the ticks seen since the strobe edge
  function automatic int stretch_f(input int s, input int mm);
    int cnt;
    if (s < 0) return 0;
    if (mm <= s) return 50;
    cnt = (mm - 1) / 16 - (s - 1) / 16;
    return (cnt >= 50) ? 0 : 50 - cnt;
  endfunction

  function automatic int duty_f(input int md, input int b, input int ph, input int st);
    int p, tr;
    p = ph % 1024;
    case (md)
      1: return b;
      2: return (((ph >> 9) & 1) == 0) ? b : 0;
      3: return (((ph >> 7) & 1) == 0) ? b : 0;
      4: begin
        tr = (ph >= 1024) ? 1023 - p : p;
        return ((tr >> 2) * b) >> 8;
      end
      5: return (p < 96 || (p >= 192 && p < 288)) ? b : 0;
      6: return (st != 0) ? b : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] rb();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic drive(input bit r, input logic [8:0] md, input logic [23:0] bv, input logic [2:0] ac);
    exp_t e;
    int nd[3];
    e.cyc = cyc + 1;
    e.led = '0;
    e.tick = 1'b0;
    if (r) begin
      m = 0;
      for (int c = 0; c < 3; c++) begin
        dprev[c] = 0;
        last_s[c] = -1;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        e.led[c] = ((m % 256) < dprev[c]) || (dprev[c] == 255);
        nd[c] = duty_f(int'(md[3*c +: 3]), int'(bv[8*c +: 8]), phase_f(m), stretch_f(last_s[c], m));
      end
      m++;
      for (int c = 0; c < 3; c++) begin
        if (ac[c]) last_s[c] = m;
        dprev[c] = nd[c];
      end
      e.tick = (m % 16 == 0);
    end
    q.push_back(e);
    reset = r;
    mode = md;
    brightness = bv;
    activity = ac;
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic [8:0] md, input logic [23:0] bv, input int len, input int pa);
    logic [2:0] a;
    for (int k = 0; k < len; k++) begin
      for (int c = 0; c < 3; c++) a[c] = (pa > 0) && ($urandom_range(0, pa - 1) == 0);
      drive(1'b0, md, bv, a);
    end
  endtask

  // monitor: pops every expectation due at this edge and compares it with the outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (led === e.led) passes++;
        else $display("FAIL led cyc=%0d got=%b exp=%b", e.cyc, led, e.led);
        checks++;
        if (tick_1ms === e.tick) passes++;
        else $display("FAIL tick_1ms cyc=%0d got=%b exp=%b", e.cyc, tick_1ms, e.tick);
      end
    end
  end

  initial begin
    logic [8:0] md;
    repeat (3) drive(1'b1, 9'o111, 24'h0040FF, 3'b000);
    seg(9'o111, 24'h0040FF, 600, 0);
    repeat (2) drive(1'b1, 9'o000, 24'h000000, 3'b000);
    seg(9'o524, {8'($urandom_range(0, 255)), 8'hFF, 8'hFF}, 33000, 0);
    seg(9'o666, {rb(), rb(), 8'hFF}, 4000, 300);
    seg(9'o350, 24'hFFFFFF, 5000, 0);
    drive(1'b1, 9'o350, 24'hFFFFFF, 3'b000);
    seg(9'o350, 24'hFFFFFF, 3000, 0);
    repeat (20) begin
      if ($urandom_range(0, 4) == 0)
        repeat ($urandom_range(1, 3)) drive(1'b1, 9'($urandom), 24'($urandom), 3'b000);
      md = 9'($urandom);
      seg(md, {rb(), rb(), rb()}, $urandom_range(200, 800), $urandom_range(20, 200));
    end
    activity = '0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dfu_status_led.md
# dfu_status_led

Parametrised multi-channel status-LED engine for TinyDFU board tops. It replaces the single free-running blink counter with per-channel selectable patterns: off, on, slow/fast blink, breathe, heartbeat and activity flash, each with PWM brightness. It sits in the board top on `clk` beside `usb_dfu_core`, and drives `pin_led` or an RGB triple from DFU state and USB activity strobes.

## Interface
Parameters:
- `CLK_HZ`, 12_000_000: frequency of `clk`; must be a multiple of 1000.
- `N_CH`, 1: number of LED channels; 3 for RGB boards.
- `PWM_BITS`, 8: brightness resolution, 1..10.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `mode`  in  3*N_CH  per-channel pattern select; channel i uses bits [3i+2:3i].
- `brightness`  in  PWM_BITS*N_CH  per-channel peak duty.
- `activity`  in  N_CH  single-cycle activity strobes, one per channel.
- `led`  out  N_CH  registered LED drive, active-high.
- `tick_1ms`  out  1  one-cycle strobe every 1 ms.

## Operation
- Prescaler counts 0..CLK_HZ/1000-1. `tick_1ms` is high for the one cycle when the count wraps.
- Phase counter: 11 bits, increments on each tick, wraps 2047→0.
  - The phase is shared by all channels, so patterns on different channels stay in lockstep.
- PWM counter: PWM_BITS wide, increments every clk, wraps naturally. `led[i] <= (pwm_cnt < duty[i]) | (duty[i] == all-ones)`.
- Duty per channel, registered every clk from `mode`, `brightness` (`B`) and phase:
  - 0 OFF: duty = 0.
  - 1 ON: duty = B.
  - 2 BLINK_SLOW: duty = B when phase[9] = 0, else 0. Period 1024 ms, 50 %.
  - 3 BLINK_FAST: duty = B when phase[7] = 0, else 0. Period 256 ms.
  - 4 BREATHE: tri = phase[10] ? ~phase[9:0] : phase[9:0]; lvl = tri[9 -: PWM_BITS]; duty = (lvl*B) >> PWM_BITS. Product width is 2*PWM_BITS with no truncation before the shift.
  - 5 HEARTBEAT: duty = B when phase[9:0] ∈ [0,96) ∪ [192,288), else 0.
  - 6 ACTIVITY: duty = B while stretch[i] ≠ 0, else 0.
  - 7: reserved, behaves as OFF.
- Activity stretch, 6 bits per channel:
  - An `activity[i]` strobe loads 50.
  - Otherwise the counter decrements on each tick while nonzero.
  - If a strobe and a tick arrive in the same cycle, the load wins (retrigger).
  - Stretch runs regardless of mode, so switching into ACTIVITY shows any pending flash.
- Mode or brightness changes are not synchronised to the PWM period. Glitching for one PWM period is acceptable.

## Timing
- Reset, on the next edge: prescaler, phase, PWM counter, duty and stretch all become 0; `led` = 0 and `tick_1ms` = 0. The first tick occurs CLK_HZ/1000 cycles after reset deasserts.
- Reset mid-pattern: `led` is low one cycle after `reset` is sampled high and stays low while `reset` is held.
- Latency:
  - A `mode`/`brightness` change updates the duty register after 1 cycle, and `led` after 2 cycles subject to the PWM compare.
  - `activity` → stretch is non-zero after 1 cycle → ACTIVITY led can assert after 3 cycles.
- Flash length: 50 ticks ±1 tick, depending on the strobe's position within the prescaler period.
- B = 0 gives a constant-low `led` in every mode. B = all-ones gives a constant-high `led` wherever duty = B.

## Structure
- Package `dfu_led_pkg`:
  - Mode codes: `LED_OFF` .. `LED_ACTIVITY`.
  - Constants: `ACT_STRETCH_MS` = 50, heartbeat window edges 0/96/192/288, phase width 11.
- Sub-module `dfu_led_channel`, instantiated N_CH times. It holds the duty mux, breathe multiply, stretch counter and PWM compare for one channel.
- The top level keeps only the shared prescaler, phase counter and PWM counter.

## Test plan
Run with CLK_HZ = 16000, so 16 clk per tick.
- Reset, mode = ON, B = 0xFF → `led` = 0 during reset and on the first cycle after; then constant 1. `tick_1ms` period is exactly 16 cycles.
- mode = BLINK_SLOW, B = 0xFF → `led` is high for ticks 0..511 and low for ticks 512..1023, repeating.
- mode = ON, B = 0x40 → over any 256-cycle window `led` is high for exactly 64 cycles. With B = 0, `led` is never high.
- mode = BREATHE, B = 0xFF → at phase 0 the duty is 0. At phase 1023 the duty is 0xFE (lvl = 0xFF). At phase 1024 the duty is 0xFE. At phase 2047 the duty is 0, then the pattern wraps.
- mode = ACTIVITY: a strobe at tick 10 gives `led` on for 50 ticks. A second strobe at tick 40 extends the flash to end at tick 90. A strobe and a tick in the same cycle reload the counter to 50.
- N_CH = 3 with modes OFF/HEARTBEAT/BLINK_FAST → each channel matches its pattern independently. Asserting `reset` mid-pattern drives all `led` bits to 0 within 1 cycle, and phase restarts from 0.
